// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: stall mask merge, exception/ERET flush FSM with
// post-flush blanking, stall watchdog, optional stall-cycle counter (PIPE_CTRL_PERF_EN).
module pipe_ctrl #(
  parameter int unsigned NSTAGE     = 6,
  parameter logic [31:0] EXC_VECTOR = 32'h00000020,
  parameter logic [31:0] ERET_TYPE  = 32'h0000000e,
  parameter int unsigned REFILL_CYC = 3,
  parameter int unsigned MAX_STALL  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stallreq,
  input  logic              except_valid,
  input  logic [31:0]       excepttype,
  input  logic [31:0]       cp0_epc,
  output logic [NSTAGE-1:0] stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              stall_timeout,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0]       stall_cycles,
`endif
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    REFILL = 2'd2
  } state_t;

  localparam logic [3:0]  REFILL_LD = 4'(REFILL_CYC);
  localparam logic [15:0] MAX16     = 16'(MAX_STALL);

  state_t            state_q;
  logic              flush_q;
  logic [31:0]       new_pc_q;
  logic [3:0]        refill_cnt_q;
  logic [15:0]       wd_cnt_q;
  logic              timeout_q;
  logic [NSTAGE-1:0] stall_mask;
  logic              req_acc;

  // Stage k stalling must also hold every older stage 0..k-1, so each bit is the
  // OR of requests from itself and all younger stages; bit 0 (PC) never requests.
  always_comb begin
    req_acc    = 1'b0;
    stall_mask = '0;
    for (int i = int'(NSTAGE) - 1; i >= 1; i--) begin
      req_acc       = req_acc | stallreq[i];
      stall_mask[i] = req_acc;
    end
    stall_mask[0] = req_acc;
  end

  assign stall = (rst || state_q == FLUSH) ? '0 : stall_mask;

  // except_valid is a one-sided strobe with no ready: it is acted on only in RUN
  // and silently dropped in FLUSH and REFILL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      flush_q      <= 1'b0;
      new_pc_q     <= '0;
      refill_cnt_q <= '0;
    end else begin
      flush_q <= 1'b0;
      unique case (state_q)
        RUN: begin
          if (except_valid) begin
            state_q  <= FLUSH;
            flush_q  <= 1'b1;
            new_pc_q <= (excepttype == ERET_TYPE) ? cp0_epc : EXC_VECTOR;
          end
        end
        FLUSH: begin
          state_q      <= REFILL;
          refill_cnt_q <= REFILL_LD;
        end
        REFILL: begin
          refill_cnt_q <= refill_cnt_q - 4'd1;
          if (refill_cnt_q <= 4'd1) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // Watchdog: run length of consecutive stalled cycles, saturating at MAX_STALL.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else if (stall == '0) begin
      wd_cnt_q <= '0;
    end else if (wd_cnt_q != MAX16) begin
      wd_cnt_q <= wd_cnt_q + 16'd1;
      if (wd_cnt_q == MAX16 - 16'd1) timeout_q <= 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk) begin
    if (rst) stall_cycles_q <= '0;
    else if (stall != '0) stall_cycles_q <= stall_cycles_q + 32'd1;
  end

  assign stall_cycles = stall_cycles_q;
`endif

  assign flush         = flush_q;
  assign new_pc        = new_pc_q;
  assign stall_timeout = timeout_q;
  assign dbg_state_o   = state_q;

endmodule
